usd_cmd_arbiter: RTL and testbench

APU-side arbiter that shares the single uSD command FIFO and result FIFO between several software requesters. It sits in the apuClk domain, on the write port of the 72-bit command FIFO and the read port of the 36-bit result FIFO. It grants command slots round-robin and records the owner of every issued command. It returns each result word to the requester that issued the matching command; the sdEngine produces exactly one result word per command, in order.

---
 rtl/usd_cmd_arbiter.sv | 149 ++++++++++++++
 tb/tb_usd_cmd_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usd_cmd_arbiter.sv
// rtl/usd_cmd_arbiter.sv - round-robin share of the uSD command/result FIFOs
// Owner queue remembers who issued each command so results route back in order.
module usd_cmd_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int OWN_DEPTH = 16
) (
  input  logic                         apuClk,
  input  logic                         sysRst,
  input  logic [NUM_REQ-1:0]           reqValid,
  input  logic [72*NUM_REQ-1:0]        reqData,
  output logic [NUM_REQ-1:0]           reqReady,
  output logic [NUM_REQ-1:0]           respValid,
  output logic [35:0]                  respData,
  input  logic [NUM_REQ-1:0]           respReady,
  output logic [71:0]                  cmdFifoData,
  output logic                         cmdFifoWrEn,
  input  logic                         cmdFifoFull,
  input  logic [35:0]                  resultFifoData,
  output logic                         resultFifoRdEn,
  input  logic                         resultFifoEmpty,
  output logic [$clog2(OWN_DEPTH):0]   outstanding,
  output logic                         orphanErr
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(OWN_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(OWN_DEPTH);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_READ = 2'd1;
  localparam logic [1:0] R_CAP  = 2'd2;
  localparam logic [1:0] R_HOLD = 2'd3;

  logic [RW-1:0] rr_ptr_q, rr_ptr_d;
  logic [71:0]   cmd_data_q, cmd_data_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [RW-1:0] own_mem_q [OWN_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [RW-1:0] owner_q, owner_d;
  logic [35:0]   resp_data_q, resp_data_d;
  logic          orphan_q, orphan_d;

  logic          grant_vld, accept, pop;
  logic [RW-1:0] grant_idx, cand;

  // First requesting index at or after rr_ptr_q; descending loop so the nearest wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = RW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (reqValid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept   = grant_vld && !cmdFifoFull && !cmd_wr_q && (count_q < DEPTH_C);
  assign pop      = (state_q == R_CAP) && (count_q != '0);
  assign reqReady = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    cmd_data_d = cmd_data_q;
    cmd_wr_d   = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (accept) begin
      rr_ptr_d   = RW'((int'(grant_idx) + 1) % NUM_REQ);
      cmd_data_d = reqData[72*grant_idx +: 72];
      cmd_wr_d   = 1'b1;
      wr_ptr_d   = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    resp_data_d = resp_data_q;
    orphan_d    = 1'b0;
    case (state_q)
      R_IDLE: if (!resultFifoEmpty) state_d = R_READ;
      R_READ: state_d = R_CAP;
      R_CAP: begin
        resp_data_d = resultFifoData;
        if (count_q != '0) begin
          owner_d = own_mem_q[rd_ptr_q];
          state_d = R_HOLD;
        end else begin
          orphan_d = 1'b1;
          state_d  = R_IDLE;
        end
      end
      R_HOLD: if (respReady[owner_q]) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge apuClk) begin
    if (sysRst) begin
      rr_ptr_q    <= '0;
      cmd_data_q  <= '0;
      cmd_wr_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= R_IDLE;
      owner_q     <= '0;
      resp_data_q <= '0;
      orphan_q    <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_wr_q    <= cmd_wr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      owner_q     <= owner_d;
      resp_data_q <= resp_data_d;
      orphan_q    <= orphan_d;
    end
  end

  // Entries are only read below count_q, so the storage needs no reset.
  always_ff @(posedge apuClk) begin
    if (accept) own_mem_q[wr_ptr_q] <= grant_idx;
  end

  assign cmdFifoData    = cmd_data_q;
  assign cmdFifoWrEn    = cmd_wr_q;
  assign resultFifoRdEn = (state_q == R_READ);
  assign respValid      = (state_q == R_HOLD) ? (NUM_REQ'(1) << owner_q) : '0;
  assign respData       = resp_data_q;
  assign outstanding    = count_q;
  assign orphanErr      = orphan_q;

endmodule

// File: tb/tb_usd_cmd_arbiter.sv
// tb/tb_usd_cmd_arbiter.sv - bench for usd_cmd_arbiter with requester and FIFO models
module tb_usd_cmd_arbiter;
  localparam int N = 2;
  localparam int D = 16;

  logic          apuClk = 1'b0;
  logic          sysRst = 1'b1;
  logic [N-1:0]  reqValid = '0;
  logic [72*N-1:0] reqData = '0;
  logic [N-1:0]  reqReady, respValid;
  logic [35:0]   respData;
  logic [N-1:0]  respReady = '0;
  logic [71:0]   cmdFifoData;
  logic          cmdFifoWrEn;
  logic          cmdFifoFull = 1'b0;
  logic [35:0]   resultFifoData = '0;
  logic          resultFifoRdEn;
  logic          resultFifoEmpty = 1'b1;
  logic [4:0]    outstanding;
  logic          orphanErr;

  usd_cmd_arbiter #(.NUM_REQ(N), .OWN_DEPTH(D)) dut (
    .apuClk(apuClk), .sysRst(sysRst), .reqValid(reqValid), .reqData(reqData),
    .reqReady(reqReady), .respValid(respValid), .respData(respData), .respReady(respReady),
    .cmdFifoData(cmdFifoData), .cmdFifoWrEn(cmdFifoWrEn), .cmdFifoFull(cmdFifoFull),
    .resultFifoData(resultFifoData), .resultFifoRdEn(resultFifoRdEn),
    .resultFifoEmpty(resultFifoEmpty), .outstanding(outstanding), .orphanErr(orphanErr)
  );

  always #5 apuClk = ~apuClk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester model: each queue front is presented until reqReady is seen.
  logic [71:0] rq0[$], rq1[$];
  logic [N-1:0] acc_s;
  logic rst_drv_s;
  initial forever begin
    @(negedge apuClk);
    acc_s = reqReady;
    rst_drv_s = sysRst;
    @(posedge apuClk); #2;
    if (!rst_drv_s) begin
      if (acc_s[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (acc_s[1] && rq1.size() > 0) void'(rq1.pop_front());
    end
    reqValid[0]     = rq0.size() > 0;
    reqData[71:0]   = (rq0.size() > 0) ? rq0[0] : 72'h0;
    reqValid[1]     = rq1.size() > 0;
    reqData[143:72] = (rq1.size() > 0) ? rq1[0] : 72'h0;
  end

  // Result FIFO model: standard read, dout valid the cycle after rd_en.
  logic [35:0] rf[$], rf_in[$];
  logic rd_s, rst_fifo_s;
  initial forever begin
    @(negedge apuClk);
    rd_s = resultFifoRdEn;
    rst_fifo_s = sysRst;
    @(posedge apuClk); #2;
    if (rst_fifo_s) begin
      rf.delete();
      rf_in.delete();
    end else begin
      if (rd_s && rf.size() > 0) resultFifoData = rf.pop_front();
      while (rf_in.size() > 0) rf.push_back(rf_in.pop_front());
    end
    resultFifoEmpty = (rf.size() == 0);
  end

  // Transaction-level expectation: owner list, round-robin pointer, result phase count.
  int          m_rr = 0, m_stage = 0, m_owner = 0, g, cyc = 0;
  bit          m_wr = 0, m_orphan = 0, n_orphan;
  logic [71:0] m_cmd = '0;
  logic [35:0] m_rdata = '0;
  int          m_own[$];
  logic [N-1:0] exp_rdy, exp_rv;
  logic [71:0] cmd_log[$];
  int          wr_cyc[$], resp_own[$];
  logic [35:0] resp_dat[$];
  int          orphan_cnt = 0;

  initial forever begin
    @(negedge apuClk);
    cyc++;
    g = -1;
    if (!cmdFifoFull && !m_wr && m_own.size() < D)
      for (int k = 0; k < N; k++)
        if (g < 0 && reqValid[(m_rr + k) % N]) g = (m_rr + k) % N;
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    exp_rv  = (m_stage == 3) ? (N'(1) << m_owner) : '0;
    chk("reqReady", reqReady, exp_rdy);
    chk("cmdFifoWrEn", cmdFifoWrEn, m_wr);
    chk("cmdFifoData", cmdFifoData, m_cmd);
    chk("outstanding", outstanding, m_own.size());
    chk("resultFifoRdEn", resultFifoRdEn, m_stage == 1);
    chk("respValid", respValid, exp_rv);
    chk("respData", respData, m_rdata);
    chk("orphanErr", orphanErr, m_orphan);

    if (cmdFifoWrEn) begin cmd_log.push_back(cmdFifoData); wr_cyc.push_back(cyc); end
    if (|(respValid & respReady)) begin
      resp_own.push_back(respValid[1] ? 1 : 0);
      resp_dat.push_back(respData);
    end
    if (orphanErr) orphan_cnt++;

    if (sysRst) begin
      m_rr = 0; m_wr = 0; m_cmd = '0; m_own.delete();
      m_stage = 0; m_owner = 0; m_rdata = '0; m_orphan = 0;
    end else begin
      n_orphan = 0;
      case (m_stage)
        0: if (!resultFifoEmpty) m_stage = 1;
        1: m_stage = 2;
        2: begin
          m_rdata = resultFifoData;
          if (m_own.size() > 0) begin m_owner = m_own.pop_front(); m_stage = 3; end
          else begin n_orphan = 1; m_stage = 0; end
        end
        default: if (respReady[m_owner]) m_stage = 0;
      endcase
      m_orphan = n_orphan;
      if (g >= 0) begin
        m_cmd = reqData[72*g +: 72];
        m_wr  = 1;
        m_own.push_back(g);
        m_rr  = (g + 1) % N;
      end else m_wr = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge apuClk);
    #1;
  endtask

  task automatic clear_logs();
    cmd_log.delete(); wr_cyc.delete(); resp_own.delete(); resp_dat.delete();
    orphan_cnt = 0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " reqReady"}, reqReady, 0);
    chk({tag, " respValid"}, respValid, 0);
    chk({tag, " respData"}, respData, 0);
    chk({tag, " cmdFifoData"}, cmdFifoData, 0);
    chk({tag, " cmdFifoWrEn"}, cmdFifoWrEn, 0);
    chk({tag, " rdEn"}, resultFifoRdEn, 0);
    chk({tag, " orphanErr"}, orphanErr, 0);
    chk({tag, " outstanding"}, outstanding, 0);
  endtask

  bit ok, hit;
  logic [35:0] held;

  initial begin
    repeat (2) @(posedge apuClk);
    @(negedge apuClk);
    all_zero("reset");
    @(posedge apuClk); #1;
    sysRst = 1'b0;
    respReady = 2'b11;

    // round-robin fairness
    clear_logs();
    for (int i = 0; i < 4; i++) begin rq0.push_back(72'hA0 + i); rq1.push_back(72'hB0 + i); end
    tick(22);
    @(negedge apuClk);
    chk("rr count", cmd_log.size(), 8);
    for (int i = 0; i < 8 && i < cmd_log.size(); i++)
      chk("rr order", cmd_log[i], ((i % 2) ? 72'hB0 : 72'hA0) + 72'(i / 2));
    ok = 1;
    for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != 2) ok = 0;
    chk("rr wr spacing", ok, 1);
    chk("rr outstanding", outstanding, 8);
    for (int i = 0; i < 8; i++) rf_in.push_back(36'h100 + 36'(i));
    tick(45);
    @(negedge apuClk);
    chk("drain count", resp_own.size(), 8);
    for (int i = 0; i < 8 && i < resp_own.size(); i++) begin
      chk("drain owner", resp_own[i], i % 2);
      chk("drain data", resp_dat[i], 36'h100 + 36'(i));
    end

    // result routing
    @(posedge apuClk); #1;
    clear_logs();
    rq1.push_back(72'hC1); tick(4);
    rq0.push_back(72'hC2); tick(4);
    rq1.push_back(72'hC3); tick(4);
    rf_in.push_back(36'h111); rf_in.push_back(36'h222); rf_in.push_back(36'h333);
    tick(25);
    @(negedge apuClk);
    chk("route count", resp_own.size(), 3);
    if (resp_own.size() == 3) begin
      chk("route own0", resp_own[0], 1); chk("route dat0", resp_dat[0], 36'h111);
      chk("route own1", resp_own[1], 0); chk("route dat1", resp_dat[1], 36'h222);
      chk("route own2", resp_own[2], 1); chk("route dat2", resp_dat[2], 36'h333);
    end
    chk("route outstanding", outstanding, 0);

    // backpressure on requester 0
    @(posedge apuClk); #1;
    clear_logs();
    respReady = 2'b10;
    rq0.push_back(72'hD0); rq0.push_back(72'hD1);
    tick(6);
    rf_in.push_back(36'h444); rf_in.push_back(36'h555);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin @(negedge apuClk); hit = respValid[0]; end
    chk("bp respValid seen", hit, 1);
    held = respData;
    chk("bp data", held, 36'h444);
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge apuClk);
      if (respData !== held || resultFifoRdEn !== 1'b0 || respValid !== 2'b01) ok = 0;
    end
    chk("bp held stable", ok, 1);
    chk("bp no resp yet", resp_own.size(), 0);
    @(posedge apuClk); #1;
    respReady = 2'b11;
    tick(15);
    @(negedge apuClk);
    chk("bp resp count", resp_own.size(), 2);
    if (resp_dat.size() > 0) chk("bp first", resp_dat[0], 36'h444);

    // command FIFO full
    @(posedge apuClk); #1;
    clear_logs();
    cmdFifoFull = 1'b1;
    rq0.push_back(72'hE0); rq1.push_back(72'hE1);
    ok = 1;
    for (int i = 0; i < 8; i++) begin @(negedge apuClk); if (reqReady !== 2'b00) ok = 0; end
    chk("full blocks", ok, 1);
    chk("full no writes", cmd_log.size(), 0);
    @(posedge apuClk); #1;
    cmdFifoFull = 1'b0;
    tick(6);
    rf_in.push_back(36'h501); rf_in.push_back(36'h502);
    tick(14);
    @(negedge apuClk);
    chk("full drained", outstanding, 0);

    // owner-queue limit
    @(posedge apuClk); #1;
    clear_logs();
    for (int i = 0; i < 17; i++) rq0.push_back(72'hF00 + 72'(i));
    tick(40);
    @(negedge apuClk);
    chk("limit outstanding", outstanding, 16);
    chk("limit writes", cmd_log.size(), 16);
    chk("limit blocked", {reqValid[0], reqReady[0]}, 2'b10);
    @(posedge apuClk); #1;
    rf_in.push_back(36'h600);
    tick(10);
    @(negedge apuClk);
    chk("limit refill", outstanding, 16);
    chk("limit 17th", cmd_log.size(), 17);
    @(posedge apuClk); #1;
    cmdFifoFull = 1'b1;
    rq0.push_back(72'hF20);
    rf_in.push_back(36'h601);
    tick(10);
    @(negedge apuClk);
    chk("limit 15", outstanding, 15);
    @(posedge apuClk); #1;
    rf_in.push_back(36'h602);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin @(negedge apuClk); hit = resultFifoRdEn; end
    chk("limit read seen", hit, 1);
    @(posedge apuClk); #1;
    cmdFifoFull = 1'b0;
    @(negedge apuClk);
    chk("simul accept", reqReady, 2'b01);
    @(negedge apuClk);
    chk("simul wr", cmdFifoWrEn, 1);
    chk("simul outstanding", outstanding, 15);
    @(posedge apuClk); #1;
    for (int i = 0; i < 15; i++) rf_in.push_back(36'h610 + 36'(i));
    tick(70);
    @(negedge apuClk);
    chk("limit drained", outstanding, 0);

    // orphan result
    @(posedge apuClk); #1;
    clear_logs();
    rf_in.push_back(36'h0AB);
    tick(10);
    @(negedge apuClk);
    chk("orphan pulses", orphan_cnt, 1);
    chk("orphan no resp", resp_own.size(), 0);

    // reset while holding a response
    @(posedge apuClk); #1;
    for (int i = 0; i < 6; i++) rq0.push_back(72'h700 + 72'(i));
    tick(14);
    respReady = 2'b00;
    rf_in.push_back(36'h777);
    hit = 0;
    for (int i = 0; i < 12 && !hit; i++) begin @(negedge apuClk); hit = respValid[0]; end
    chk("rst hold seen", hit, 1);
    chk("rst pre outstanding", outstanding, 5);
    @(posedge apuClk); #1;
    sysRst = 1'b1;
    @(posedge apuClk); #1;
    sysRst = 1'b0;
    @(negedge apuClk);
    all_zero("midrst");
    @(posedge apuClk); #1;
    clear_logs();
    respReady = 2'b11;
    rq0.push_back(72'h800); rq1.push_back(72'h801);
    tick(6);
    @(negedge apuClk);
    chk("post-rst writes", cmd_log.size(), 2);
    if (cmd_log.size() > 0) chk("post-rst first grant", cmd_log[0], 72'h800);
    @(posedge apuClk); #1;
    rf_in.push_back(36'h901); rf_in.push_back(36'h902);
    tick(12);
    @(negedge apuClk);
    chk("final outstanding", outstanding, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
